// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forwarding
// selects and the hard-wired zero register, plus the forwarding priority helper.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // EX/MEM is the younger producer, so it must win over MEM/WB.
    function automatic logic [1:0] fwd_select(
        input logic       mem_reg_write,
        input logic [4:0] mem_rd_addr,
        input logic       wb_reg_write,
        input logic [4:0] wb_rd_addr,
        input logic [4:0] src_addr
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem_reg_write && (mem_rd_addr != REG_ZERO) && (mem_rd_addr == src_addr)) begin
            sel = FWD_MEM;
        end else if (wb_reg_write && (wb_rd_addr != REG_ZERO) && (wb_rd_addr == src_addr)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// EX-stage forwarding selects for ALU operands A (rs) and B (rt); purely combinational.
module forward_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic       mem_reg_write,
    input  logic [4:0] mem_rd_addr,
    input  logic       wb_reg_write,
    input  logic [4:0] wb_rd_addr,
    input  logic [4:0] ex_rs_addr,
    input  logic [4:0] ex_rt_addr,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    assign fwd_a = fwd_select(mem_reg_write, mem_rd_addr, wb_reg_write, wb_rd_addr, ex_rs_addr);
    assign fwd_b = fwd_select(mem_reg_write, mem_rd_addr, wb_reg_write, wb_rd_addr, ex_rt_addr);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller: load-use stalls, taken-branch flushes, data-memory
// wait holds with a timeout watchdog, forwarding selects and a stall counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rs_addr,
    input  logic [4:0]       ex_rt_addr,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd_addr,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_rd_addr,
    input  logic             mem_branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic             pipe_hold,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count,
    output logic             err
);

    localparam int unsigned      WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    hz_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              load_use;

    // rt only matters when the ID instruction actually reads it (R-type, beq, sw).
    assign load_use = ex_mem_read && (ex_rt_addr != REG_ZERO) &&
                      ((ex_rt_addr == id_rs_addr) || (id_uses_rt && (ex_rt_addr == id_rt_addr)));

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        pipe_hold   = 1'b0;
        err         = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    exmem_flush = 1'b1;
                end else if (mem_busy) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // MEM is frozen here, so a branch flag from it is stale and ignored.
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                pipe_hold  = 1'b1;
                if (!mem_busy) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_ERR: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                pipe_hold  = 1'b1;
                err        = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_count = stall_cnt_q;

    forward_unit u_forward_unit (
        .mem_reg_write (mem_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .ex_rs_addr    (ex_rs_addr),
        .ex_rt_addr    (ex_rt_addr),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised bench for pipeline_hazard_ctrl against a behavioural model; a second
// instance with a 4-bit stall counter exercises saturation on the same stimulus.
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 64;
    localparam int SMALL_W = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs_addr, id_rt_addr, ex_rs_addr, ex_rt_addr, mem_rd_addr, wb_rd_addr;
    logic       id_uses_rt, ex_mem_read, mem_reg_write, wb_reg_write, mem_branch_taken, mem_busy;

    logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold, err;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_count;

    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_exmem_flush, s_pipe_hold, s_err;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [SMALL_W-1:0] s_stall_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: sticky error, waiting flag, consecutive busy cycles, total stall cycles.
    bit m_err, m_wait;
    int m_busy_run, m_stalls;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
        .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr),
        .mem_branch_taken(mem_branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .exmem_flush(exmem_flush), .pipe_hold(pipe_hold),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count), .err(err)
    );

    pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(SMALL_W)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
        .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr),
        .mem_branch_taken(mem_branch_taken), .mem_busy(mem_busy),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
        .idex_bubble(s_idex_bubble), .exmem_flush(s_exmem_flush), .pipe_hold(s_pipe_hold),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_count(s_stall_count), .err(s_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [1:0] model_fwd(input logic [4:0] src);
        if (mem_reg_write && mem_rd_addr != 0 && mem_rd_addr == src) return 2'b10;
        if (wb_reg_write && wb_rd_addr != 0 && wb_rd_addr == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic set_idle();
        id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rs_addr = 5'd0; ex_rt_addr = 5'd0;
        mem_reg_write = 1'b0; mem_rd_addr = 5'd0; wb_reg_write = 1'b0; wb_rd_addr = 5'd0;
        mem_branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic run_cycle(input string tag);
        bit e_pc, e_ifw, e_iff, e_bub, e_exf, e_hold, lu;
        int small_max;
        #1;
        small_max = (1 << SMALL_W) - 1;
        lu = ex_mem_read && ex_rt_addr != 0 &&
             (ex_rt_addr == id_rs_addr || (id_uses_rt && ex_rt_addr == id_rt_addr));
        e_pc = 1; e_ifw = 1; e_iff = 0; e_bub = 0; e_exf = 0; e_hold = 0;
        if (m_err || m_wait) begin
            e_pc = 0; e_ifw = 0; e_hold = 1;
        end else if (mem_branch_taken) begin
            e_iff = 1; e_bub = 1; e_exf = 1;
        end else if (mem_busy) begin
            e_pc = 0; e_ifw = 0; e_hold = 1;
        end else if (lu) begin
            e_pc = 0; e_ifw = 0; e_bub = 1;
        end
        $display("cyc %0d %s: pc_write=%0b ifid_write=%0b ifid_flush=%0b idex_bubble=%0b exmem_flush=%0b pipe_hold=%0b fwd_a=%b fwd_b=%b stall_count=%0d/%0d err=%0b",
                 cyc, tag, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold,
                 fwd_a, fwd_b, stall_count, s_stall_count, err);
        check_eq({tag, ".pc_write"},    32'(pc_write),    32'(e_pc));
        check_eq({tag, ".ifid_write"},  32'(ifid_write),  32'(e_ifw));
        check_eq({tag, ".ifid_flush"},  32'(ifid_flush),  32'(e_iff));
        check_eq({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(e_bub));
        check_eq({tag, ".exmem_flush"}, 32'(exmem_flush), 32'(e_exf));
        check_eq({tag, ".pipe_hold"},   32'(pipe_hold),   32'(e_hold));
        check_eq({tag, ".fwd_a"},       32'(fwd_a),       32'(model_fwd(ex_rs_addr)));
        check_eq({tag, ".fwd_b"},       32'(fwd_b),       32'(model_fwd(ex_rt_addr)));
        check_eq({tag, ".err"},         32'(err),         32'(m_err));
        check_eq({tag, ".stall_count"}, 32'(stall_count), 32'(m_stalls > 65535 ? 65535 : m_stalls));
        check_eq({tag, ".small_stall_count"}, 32'(s_stall_count),
                 32'(m_stalls > small_max ? small_max : m_stalls));
        check_eq({tag, ".small_err"},   32'(s_err),       32'(m_err));
        @(posedge clk);
        if (!e_pc) m_stalls++;
        if (!m_err) begin
            if (m_wait) begin
                if (!mem_busy) begin
                    m_wait = 0;
                    m_busy_run = 0;
                end else begin
                    m_busy_run++;
                    if (m_busy_run >= TIMEOUT) m_err = 1;
                end
            end else if (mem_busy && !mem_branch_taken) begin
                m_wait = 1;
                m_busy_run = 1;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    // Asserts reset mid-phase and checks the asynchronous effect before any clock edge.
    task automatic apply_reset(input string tag);
        set_idle();
        #2;
        rst_n = 1'b0;
        #1;
        m_err = 0; m_wait = 0; m_busy_run = 0; m_stalls = 0;
        check_eq({tag, ".rst_err"},         32'(err),         32'd0);
        check_eq({tag, ".rst_pc_write"},    32'(pc_write),    32'd1);
        check_eq({tag, ".rst_ifid_write"},  32'(ifid_write),  32'd1);
        check_eq({tag, ".rst_pipe_hold"},   32'(pipe_hold),   32'd0);
        check_eq({tag, ".rst_stall_count"}, 32'(stall_count), 32'd0);
        check_eq({tag, ".rst_fwd_a"},       32'(fwd_a),       32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        m_err = 0; m_wait = 0; m_busy_run = 0; m_stalls = 0;
        @(negedge clk);
        apply_reset("init");

        // lw $2 in EX, add with rs=2 in ID, then the load moves on.
        set_idle(); ex_mem_read = 1'b1; ex_rt_addr = 5'd2; id_rs_addr = 5'd2;
        run_cycle("load_use");
        set_idle();
        run_cycle("load_use_after");

        // Load-use through rt only when the ID instruction reads rt.
        set_idle(); ex_mem_read = 1'b1; ex_rt_addr = 5'd3; id_rt_addr = 5'd3; id_uses_rt = 1'b1;
        run_cycle("load_use_rt");
        id_uses_rt = 1'b0;
        run_cycle("no_use_rt");

        // Branch beats a simultaneous load-use hazard.
        set_idle(); ex_mem_read = 1'b1; ex_rt_addr = 5'd2; id_rs_addr = 5'd2; mem_branch_taken = 1'b1;
        run_cycle("branch_over_lu");

        // Three busy cycles, then the release cycle, then free running.
        set_idle(); mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) run_cycle("busy3");
        mem_busy = 1'b0;
        run_cycle("busy3_release");
        run_cycle("busy3_after");

        // Forwarding priority and zero-register cases.
        set_idle(); mem_reg_write = 1'b1; wb_reg_write = 1'b1;
        mem_rd_addr = 5'd5; wb_rd_addr = 5'd5; ex_rs_addr = 5'd5;
        run_cycle("fwd_mem_prio");
        mem_rd_addr = 5'd0;
        run_cycle("fwd_wb");
        mem_rd_addr = 5'd0; wb_rd_addr = 5'd0; ex_rt_addr = 5'd0;
        run_cycle("fwd_zero");

        // Random traffic; small register numbers to make matches frequent.
        for (int i = 0; i < 400; i++) begin
            id_rs_addr       = 5'($urandom_range(0, 7));
            id_rt_addr       = 5'($urandom_range(0, 7));
            id_uses_rt       = 1'($urandom_range(0, 1));
            ex_mem_read      = 1'($urandom_range(0, 1));
            ex_rs_addr       = 5'($urandom_range(0, 7));
            ex_rt_addr       = 5'($urandom_range(0, 7));
            mem_reg_write    = 1'($urandom_range(0, 1));
            mem_rd_addr      = 5'($urandom_range(0, 7));
            wb_reg_write     = 1'($urandom_range(0, 1));
            wb_rd_addr       = 5'($urandom_range(0, 7));
            mem_branch_taken = ($urandom_range(0, 7) == 0);
            mem_busy         = ($urandom_range(0, 4) == 0);
            run_cycle("rand");
        end

        // Watchdog: hold busy past TIMEOUT, drop it, error must stick.
        apply_reset("pre_timeout");
        set_idle(); mem_busy = 1'b1;
        for (int i = 0; i < TIMEOUT + 4; i++) begin
            mem_branch_taken = ($urandom_range(0, 3) == 0) && (i > 0);
            run_cycle("timeout");
        end
        set_idle();
        for (int i = 0; i < 3; i++) run_cycle("err_sticky");
        apply_reset("err_reset");
        run_cycle("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
